// File: rtl/troco_pkg.sv
// Shared types and constants for the change-return (troco) block.
package troco_pkg;

  localparam int CREDIT_W = 9;
  localparam logic [3:0] UNIT_25 = 4'd1;
  localparam logic [3:0] UNIT_50 = 4'd2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    REQ50,
    REQ25,
    GAP,
    DONE,
    FAULT
  } troco_state_e;

endpackage

// File: rtl/troco_onehot_dec.sv
// Combinational decoder: one-hot credit vector to a 25-cent unit count.
module troco_onehot_dec
  import troco_pkg::*;
(
  input  logic [CREDIT_W-1:0] credit,
  output logic [3:0]          units,
  output logic                valid
);

  // Exactly one bit set is a legal credit; units is the index of that bit.
  always_comb begin
    units = '0;
    valid = $onehot(credit);
    for (int i = 0; i < CREDIT_W; i++) begin
      if (credit[i]) units = 4'(i);
    end
  end

endmodule

// File: rtl/devolve_troco.sv
// Change-return sequencer: ejects 50/25-cent coins for the credit owed.
// Define DEVOLVE_TROCO_TIMEOUT_EN to enable the ejector acknowledge timeout and sticky fault.
module devolve_troco
  import troco_pkg::*;
#(
  parameter int PRICE_UNITS = 6,
  parameter int ACK_TIMEOUT = 50_000_000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [CREDIT_W-1:0] i_credit,
  input  logic                i_vend,
  input  logic                i_cancel,
  input  logic                i_eject_ack,
  output logic                o_eject_50,
  output logic                o_eject_25,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic                o_fault
);

  localparam logic [3:0] PRICE = 4'(PRICE_UNITS);

  troco_state_e state, state_next;
  logic [3:0]   remaining, remaining_next;
  logic         err_next;
  logic [3:0]   units;
  logic         units_valid;
  logic         timed_out;

  troco_onehot_dec u_dec (
    .credit (i_credit),
    .units  (units),
    .valid  (units_valid)
  );

`ifdef DEVOLVE_TROCO_TIMEOUT_EN
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  logic [CNT_W-1:0] ack_cnt;
  logic             in_req;

  assign in_req    = (state == REQ50) || (state == REQ25);
  assign timed_out = in_req && (ack_cnt == CNT_W'(ACK_TIMEOUT - 1));

  // Counts cycles spent waiting in a request state; restarts on every new request.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) ack_cnt <= '0;
    else if (in_req && (state_next == state)) ack_cnt <= ack_cnt + 1'b1;
    else ack_cnt <= '0;
  end
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= IDLE;
      remaining <= '0;
      o_err     <= 1'b0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      o_err     <= err_next;
    end
  end

  // Credit is only sampled in IDLE; cancel takes priority over vend.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    err_next       = 1'b0;
    case (state)
      IDLE: begin
        if (i_cancel) begin
          if (!units_valid) err_next = 1'b1;
          else begin
            remaining_next = units;
            state_next     = LOAD;
          end
        end else if (i_vend) begin
          if (!units_valid || (units < PRICE)) err_next = 1'b1;
          else begin
            remaining_next = units - PRICE;
            state_next     = LOAD;
          end
        end
      end
      LOAD, GAP: begin
        if (remaining >= UNIT_50)      state_next = REQ50;
        else if (remaining == UNIT_25) state_next = REQ25;
        else                           state_next = DONE;
      end
      REQ50: begin
        if (i_eject_ack) begin
          remaining_next = remaining - UNIT_50;
          state_next     = GAP;
        end else if (timed_out) begin
          state_next = FAULT;
        end
      end
      REQ25: begin
        if (i_eject_ack) begin
          remaining_next = remaining - UNIT_25;
          state_next     = GAP;
        end else if (timed_out) begin
          state_next = FAULT;
        end
      end
      DONE:    state_next = IDLE;
      FAULT:   state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  assign o_eject_50 = (state == REQ50);
  assign o_eject_25 = (state == REQ25);
  assign o_busy     = (state != IDLE);
  assign o_done     = (state == DONE);

`ifdef DEVOLVE_TROCO_TIMEOUT_EN
  assign o_fault = (state == FAULT);
`else
  assign o_fault = 1'b0;
`endif

endmodule

// File: tb/tb_devolve_troco.sv
// Directed self-checking bench for devolve_troco (PRICE_UNITS = 6, ACK_TIMEOUT = 10).
module tb_devolve_troco;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic [8:0] i_credit = '0;
  logic       i_vend = 1'b0;
  logic       i_cancel = 1'b0;
  logic       i_eject_ack = 1'b0;
  logic       o_eject_50, o_eject_25, o_busy, o_done, o_err, o_fault;

  int n_checks = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  devolve_troco #(.PRICE_UNITS(6), .ACK_TIMEOUT(10)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_credit    (i_credit),
    .i_vend      (i_vend),
    .i_cancel    (i_cancel),
    .i_eject_ack (i_eject_ack),
    .o_eject_50  (o_eject_50),
    .o_eject_25  (o_eject_25),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_fault     (o_fault)
  );

  // Output vector order: {eject_50, eject_25, busy, done, err, fault}
  task automatic check_output(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {o_eject_50, o_eject_25, o_busy, o_done, o_err, o_fault};
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; pulses vend/cancel for exactly one clock.
  task automatic apply_stimulus(input logic vend, input logic cancel, input logic [8:0] credit);
    i_credit = credit;
    i_vend   = vend;
    i_cancel = cancel;
    @(negedge i_clk);
    i_vend   = 1'b0;
    i_cancel = 1'b0;
  endtask

  // Expects a coin request on the next cycle, holds it without ack, then acks and checks GAP.
  task automatic expect_coin(input string tag, input logic is50, input int hold);
    @(negedge i_clk);
    check_output({tag, "_req"}, is50 ? 6'b101000 : 6'b011000);
    for (int k = 0; k < hold; k++) begin
      @(negedge i_clk);
      check_output({tag, "_hold"}, is50 ? 6'b101000 : 6'b011000);
    end
    i_eject_ack = 1'b1;
    @(negedge i_clk);
    i_eject_ack = 1'b0;
    check_output({tag, "_gap"}, 6'b001000);
  endtask

  task automatic expect_done(input string tag);
    @(negedge i_clk);
    check_output({tag, "_done"}, 6'b001100);
    @(negedge i_clk);
    check_output({tag, "_idle"}, 6'b000000);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge i_clk);
    check_output("reset", 6'b000000);
    i_rst = 1'b1;
    @(negedge i_clk);
    check_output("post_reset", 6'b000000);

    // Ack while idle is ignored
    i_eject_ack = 1'b1;
    @(negedge i_clk);
    i_eject_ack = 1'b0;
    check_output("ack_idle", 6'b000000);

    // Vend with R$2.00: one 50-cent coin
    apply_stimulus(1'b1, 1'b0, 9'h100);
    check_output("v8_load", 6'b001000);
    expect_coin("v8_c1", 1'b1, 2);
    expect_done("v8");

    // Cancel with R$1.75: 50,50,50,25; new requests while busy are ignored
    apply_stimulus(1'b0, 1'b1, 9'h080);
    check_output("c7_load", 6'b001000);
    i_vend   = 1'b1;
    i_cancel = 1'b1;
    i_credit = 9'h001;
    expect_coin("c7_c1", 1'b1, 0);
    i_vend   = 1'b0;
    i_cancel = 1'b0;
    i_credit = 9'h080;
    expect_coin("c7_c2", 1'b1, 1);
    expect_coin("c7_c3", 1'b1, 0);
    expect_coin("c7_c4", 1'b0, 1);
    expect_done("c7");

    // Vend with insufficient credit
    apply_stimulus(1'b1, 1'b0, 9'h008);
    check_output("v3_err", 6'b000010);
    @(negedge i_clk);
    check_output("v3_after", 6'b000000);

    // Cancel with multi-hot credit
    apply_stimulus(1'b0, 1'b1, 9'b000010010);
    check_output("mh_err", 6'b000010);
    @(negedge i_clk);
    check_output("mh_after", 6'b000000);

    // Vend with zero-hot credit
    apply_stimulus(1'b1, 1'b0, 9'h000);
    check_output("zh_err", 6'b000010);
    @(negedge i_clk);
    check_output("zh_after", 6'b000000);

    // Vend and cancel together with R$0.50: cancel wins, one 50-cent coin
    apply_stimulus(1'b1, 1'b1, 9'h004);
    check_output("vc_load", 6'b001000);
    expect_coin("vc_c1", 1'b1, 0);
    expect_done("vc");

    // Exact price: no change, straight to done
    apply_stimulus(1'b1, 1'b0, 9'h040);
    check_output("ex_load", 6'b001000);
    expect_done("ex");

    // Reset while a 50-cent request is active
    apply_stimulus(1'b0, 1'b1, 9'h100);
    check_output("rm_load", 6'b001000);
    @(negedge i_clk);
    check_output("rm_req", 6'b101000);
    i_rst = 1'b0;
    #1;
    check_output("rm_in_reset", 6'b000000);
    @(negedge i_clk);
    i_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check_output("rm_no_resume", 6'b000000);
    end

    // Normal operation after reset: R$0.25 cancel
    apply_stimulus(1'b0, 1'b1, 9'h002);
    check_output("c1_load", 6'b001000);
    expect_coin("c1_c1", 1'b0, 0);
    expect_done("c1");

`ifdef DEVOLVE_TROCO_TIMEOUT_EN
    // No ack: fault 10 cycles after the request, sticky until reset
    apply_stimulus(1'b0, 1'b1, 9'h080);
    check_output("to_load", 6'b001000);
    @(negedge i_clk);
    check_output("to_req", 6'b101000);
    for (int k = 1; k < 10; k++) begin
      @(negedge i_clk);
      check_output("to_wait", 6'b101000);
    end
    @(negedge i_clk);
    check_output("to_fault", 6'b001001);
    i_eject_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check_output("to_sticky", 6'b001001);
    end
    i_eject_ack = 1'b0;
    i_rst = 1'b0;
    #1;
    check_output("to_reset", 6'b000000);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    check_output("to_after", 6'b000000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
